// File: rtl/macro_cnt_decr.sv
// macro_cnt_decr: parametrised registered down-counter / timer with variable
// step, wrap or saturate on underflow, and an IDLE/RUN/EXPIRED status FSM.
// Optional feature macro: MACRO_CNT_DECR_AUTORELOAD_EN (periodic-tick mode,
// reloads from the reload register instead of expiring).
module macro_cnt_decr #(
    parameter int unsigned WIDTH      = 5,
    parameter int unsigned STEP_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_load_value,
    input  logic                  i_en,
    input  logic [STEP_WIDTH-1:0] i_step,
    input  logic                  i_sat,
    output logic [WIDTH-1:0]      o_q,
    output logic                  o_borrow,
    output logic                  o_zero,
    output logic                  o_busy,
    output logic                  o_expired
);

    localparam int unsigned DIFF_W = WIDTH + 1;

`ifdef MACRO_CNT_DECR_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  reload_q;
    logic [WIDTH-1:0]  reload_nxt;
    logic [WIDTH-1:0]  q_nxt;
    logic              borrow_nxt;
    logic [DIFF_W-1:0] diff;
    logic              under;
    logic              reach_zero;
    logic              count_c;

    // Extended-width subtraction; the top bit is the borrow out.
    assign diff       = {1'b0, o_q} - DIFF_W'(i_step);
    assign under      = diff[WIDTH];
    assign reach_zero = !under && (diff[WIDTH-1:0] == '0);
    assign count_c    = (state == ST_RUN) && i_en && (i_step != '0);

    // Next count, borrow, reload and state; load has top priority.
    always_comb begin
        q_nxt      = o_q;
        reload_nxt = reload_q;
        state_nxt  = state;
        borrow_nxt = 1'b0;
        if (i_load) begin
            q_nxt      = i_load_value;
            reload_nxt = i_load_value;
            state_nxt  = (i_load_value != '0) ? ST_RUN : ST_EXPIRED;
        end else if (count_c) begin
            if (!under && !reach_zero) begin
                q_nxt = diff[WIDTH-1:0];
            end else if (AUTORELOAD && (reload_q != '0)) begin
                // Periodic tick: restart from the reload value, pulse borrow.
                q_nxt      = reload_q;
                borrow_nxt = 1'b1;
            end else if (reach_zero) begin
                q_nxt     = '0;
                state_nxt = ST_EXPIRED;
            end else begin
                q_nxt      = i_sat ? '0 : diff[WIDTH-1:0];
                borrow_nxt = 1'b1;
                state_nxt  = ST_EXPIRED;
            end
        end
    end

    // State, reload register and all outputs registered together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            reload_q  <= '0;
            o_q       <= '0;
            o_borrow  <= 1'b0;
            o_zero    <= 1'b1;
            o_busy    <= 1'b0;
            o_expired <= 1'b0;
        end else begin
            state     <= state_nxt;
            reload_q  <= reload_nxt;
            o_q       <= q_nxt;
            o_borrow  <= borrow_nxt;
            o_zero    <= (q_nxt == '0);
            o_busy    <= (state_nxt == ST_RUN);
            o_expired <= (state_nxt == ST_EXPIRED);
        end
    end

endmodule

// File: tb/tb_macro_cnt_decr.sv
// Randomised self-checking bench for macro_cnt_decr with an integer-level model
// plus directed literal checks of the documented sequences.
module tb_macro_cnt_decr;

    localparam int unsigned WIDTH      = 5;
    localparam int unsigned STEP_WIDTH = 5;
    localparam int          MODULUS    = 1 << WIDTH;

`ifdef MACRO_CNT_DECR_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  i_load = 1'b0;
    logic [WIDTH-1:0]      i_load_value = '0;
    logic                  i_en = 1'b0;
    logic [STEP_WIDTH-1:0] i_step = '0;
    logic                  i_sat = 1'b0;
    logic [WIDTH-1:0]      o_q;
    logic                  o_borrow;
    logic                  o_zero;
    logic                  o_busy;
    logic                  o_expired;

    int vectors = 0;
    int miscompares = 0;

    // Model: 0 = idle, 1 = run, 2 = expired.
    int m_q = 0;
    int m_rl = 0;
    int m_st = 0;
    bit m_b = 1'b0;

    macro_cnt_decr #(.WIDTH(WIDTH), .STEP_WIDTH(STEP_WIDTH)) dut (
        .clk(clk), .reset(reset), .i_load(i_load), .i_load_value(i_load_value),
        .i_en(i_en), .i_step(i_step), .i_sat(i_sat), .o_q(o_q),
        .o_borrow(o_borrow), .o_zero(o_zero), .o_busy(o_busy), .o_expired(o_expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference in plain integer arithmetic.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q = 0; m_rl = 0; m_st = 0; m_b = 1'b0;
        end else if (i_load) begin
            m_q = int'(i_load_value);
            m_rl = m_q;
            m_b = 1'b0;
            m_st = (m_q != 0) ? 1 : 2;
        end else begin
            int d;
            m_b = 1'b0;
            if (m_st == 1 && i_en && i_step != 0) begin
                d = m_q - int'(i_step);
                if (d > 0) m_q = d;
                else if (AUTO && m_rl != 0) begin m_q = m_rl; m_b = 1'b1; end
                else if (d == 0) begin m_q = 0; m_st = 2; end
                else begin m_b = 1'b1; m_q = i_sat ? 0 : d + MODULUS; m_st = 2; end
            end
        end
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        check("q", int'(o_q), m_q);
        check("borrow", int'(o_borrow), int'(m_b));
        check("zero", int'(o_zero), int'(m_q == 0));
        check("busy", int'(o_busy), int'(m_st == 1));
        check("expired", int'(o_expired), int'(m_st == 2));
    end

    task automatic cyc(input bit l, input int lv, input bit e, input int s, input bit sat);
        i_load = l;
        i_load_value = WIDTH'(lv);
        i_en = e;
        i_step = STEP_WIDTH'(s);
        i_sat = sat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        check("rst_q", int'(o_q), 0);
        check("rst_zero", int'(o_zero), 1);
        check("rst_busy", int'(o_busy), 0);
        check("rst_expired", int'(o_expired), 0);
        check("rst_borrow", int'(o_borrow), 0);
        cyc(0, 0, 1, 1, 0);
        check("idle_hold", int'(o_q), 0);

`ifndef MACRO_CNT_DECR_AUTORELOAD_EN
        cyc(1, 3, 1, 1, 0); check("cd3_q", int'(o_q), 3); check("cd3_busy", int'(o_busy), 1);
        cyc(0, 0, 1, 1, 0); check("cd2_q", int'(o_q), 2);
        cyc(0, 0, 1, 1, 0); check("cd1_q", int'(o_q), 1);
        cyc(0, 0, 1, 1, 0); check("cd0_q", int'(o_q), 0);
        check("cd0_exp", int'(o_expired), 1); check("cd0_borrow", int'(o_borrow), 0);
        cyc(0, 0, 1, 1, 0); check("cd0_hold", int'(o_q), 0);

        cyc(1, 2, 0, 3, 0);
        cyc(0, 0, 1, 3, 0); check("wrap_q", int'(o_q), 31);
        check("wrap_borrow", int'(o_borrow), 1); check("wrap_exp", int'(o_expired), 1);
        cyc(0, 0, 1, 3, 0); check("wrap_hold", int'(o_q), 31);
        check("wrap_borrow_clr", int'(o_borrow), 0);

        cyc(1, 2, 0, 3, 1);
        cyc(0, 0, 1, 3, 1); check("sat_q", int'(o_q), 0);
        check("sat_borrow", int'(o_borrow), 1); check("sat_exp", int'(o_expired), 1);
        cyc(0, 0, 1, 3, 1); check("sat_borrow_clr", int'(o_borrow), 0);
`else
        cyc(1, 2, 1, 1, 0); check("ar_q0", int'(o_q), 2);
        cyc(0, 0, 1, 1, 0); check("ar_q1", int'(o_q), 1); check("ar_b1", int'(o_borrow), 0);
        cyc(0, 0, 1, 1, 0); check("ar_q2", int'(o_q), 2); check("ar_b2", int'(o_borrow), 1);
        check("ar_busy", int'(o_busy), 1);
        cyc(0, 0, 1, 1, 0); check("ar_q3", int'(o_q), 1); check("ar_b3", int'(o_borrow), 0);
        cyc(0, 0, 1, 1, 0); check("ar_q4", int'(o_q), 2); check("ar_b4", int'(o_borrow), 1);
`endif

        cyc(1, 10, 0, 4, 0); check("en_load", int'(o_q), 10);
        cyc(0, 0, 1, 4, 0);  check("en_a", int'(o_q), 6);
        cyc(0, 0, 0, 4, 0);  check("en_b", int'(o_q), 6);
        cyc(0, 0, 1, 4, 0);  check("en_c", int'(o_q), 2);
        cyc(1, 7, 1, 4, 0);  check("load_prio", int'(o_q), 7);
        cyc(0, 0, 1, 0, 0);  check("step0_hold", int'(o_q), 7);
        cyc(1, 0, 1, 1, 0);  check("load0_exp", int'(o_expired), 1);
        cyc(1, 9, 1, 2, 0);
        #2 reset = 1'b1;
        #1 check("async_q", int'(o_q), 0); check("async_zero", int'(o_zero), 1);
        check("async_busy", int'(o_busy), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            bit l;
            int lv;
            l = ($urandom_range(0, 7) == 0);
            lv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, MODULUS - 1));
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            cyc(l, lv, $urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, (1 << STEP_WIDTH) - 1)),
                $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
